// File: rtl/add_mod_if.sv
// ---------------------------------------------------------------------------
// parameters_pkg / add_mod_if
//
// Purpose:
//   parameters_pkg holds the Ed448 field constants shared by the
//   point-arithmetic datapath. It lives in this file so that it is compiled
//   ahead of everything that imports it.
//
//   add_mod_if groups the start/done request bus of the modular adder.
//   - The master (requester) drives start, a and b, and observes sum and done.
//   - The slave (add_mod) does the reverse.
//
// Interface signals:
//   start  1           one-cycle request pulse
//   a      DATA_WIDTH  operand A, unsigned
//   b      DATA_WIDTH  operand B, unsigned
//   sum    DATA_WIDTH  registered result (a + b) mod p
//   done   1           result-valid level
// ---------------------------------------------------------------------------

package parameters_pkg;

    // Width of one field element.
    localparam int DATA_WIDTH = 448;

    // Bits the adder processes per clock.
    localparam int LIMB_WIDTH = 64;

    // Ed448 prime p = 2^448 - 2^224 - 1.
    // Every bit is set except bit 224.
    localparam logic [DATA_WIDTH-1:0] MODULUS =
        {{(DATA_WIDTH-225){1'b1}}, 1'b0, {224{1'b1}}};

endpackage : parameters_pkg

interface add_mod_if
    import parameters_pkg::*;
();

    logic                  start;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] sum;
    logic                  done;

    // Requester side: issues operands, consumes the result.
    modport master (
        output start,
        output a,
        output b,
        input  sum,
        input  done
    );

    // Adder side: consumes operands, produces the result.
    modport slave (
        input  start,
        input  a,
        input  b,
        output sum,
        output done
    );

endinterface : add_mod_if

// File: rtl/add_mod.sv
// ---------------------------------------------------------------------------
// add_mod
//
// Purpose:
//   Limb-serial modular adder for the Ed448 base field.
//   It computes sum = (a + b) mod p with p = 2^448 - 2^224 - 1.
//
//   Each RUN cycle handles one 64-bit limb, least significant limb first.
//   Two chains run side by side in the same cycle:
//   - the plain sum S = a + b, with carry c;
//   - the trial difference T = S - p, with borrow w.
//   T is fed from the same-cycle limb of S, so it accumulates (a + b) - p.
//   A single select cycle then keeps T when a + b >= p and S otherwise.
//   That is exactly one conditional subtraction of p.
//
//   Timing: start captured at edge E0, done rises after edge E0+8
//   (7 limb cycles + 1 select cycle).
//
// Ports:
//   clk  in   rising-edge clock
//   rst  in   asynchronous, active-high reset
//   bus  slave modport of add_mod_if
//        (start, a, b in; sum, done out)
// ---------------------------------------------------------------------------

module add_mod
    import parameters_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    add_mod_if.slave  bus
);

    // -----------------------------------------------------------------------
    // Derived sizes
    // -----------------------------------------------------------------------
    localparam int NUM_LIMBS = DATA_WIDTH / LIMB_WIDTH;
    localparam int CNT_WIDTH = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_LIMB = CNT_WIDTH'(NUM_LIMBS - 1);

    // -----------------------------------------------------------------------
    // Controller states
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SEL  = 2'd2
    } state_e;

    // -----------------------------------------------------------------------
    // State registers and their next-state values
    // -----------------------------------------------------------------------
    state_e                state_q,   state_d;
    logic [CNT_WIDTH-1:0]  cnt_q,     cnt_d;
    logic [DATA_WIDTH-1:0] a_q,       a_d;
    logic [DATA_WIDTH-1:0] b_q,       b_d;
    logic [DATA_WIDTH-1:0] s_q,       s_d;
    logic [DATA_WIDTH-1:0] t_q,       t_d;
    logic                  c_q,       c_d;
    logic                  w_q,       w_d;
    logic [DATA_WIDTH-1:0] sum_q,     sum_d;
    logic                  done_q,    done_d;

    // -----------------------------------------------------------------------
    // Per-limb datapath signals
    // -----------------------------------------------------------------------
    logic [LIMB_WIDTH-1:0] a_limb;
    logic [LIMB_WIDTH-1:0] b_limb;
    logic [LIMB_WIDTH-1:0] p_limb;
    logic [LIMB_WIDTH:0]   s_ext;
    logic [LIMB_WIDTH:0]   t_ext;

    // -----------------------------------------------------------------------
    // Limb datapath
    //
    // Both chains are evaluated every cycle; only RUN commits their results.
    //
    // The trial subtraction is done one bit wider than a limb. When the
    // result goes negative, the extra top bit reads 1 and serves as the
    // borrow. The most negative case is 0 - (2^64 - 1) - 1 = -2^64, which
    // still fits in 65 bits, so the borrow is never lost.
    // -----------------------------------------------------------------------
    always_comb begin
        a_limb = a_q[cnt_q * LIMB_WIDTH +: LIMB_WIDTH];
        b_limb = b_q[cnt_q * LIMB_WIDTH +: LIMB_WIDTH];
        p_limb = MODULUS[cnt_q * LIMB_WIDTH +: LIMB_WIDTH];

        s_ext = {1'b0, a_limb}
              + {1'b0, b_limb}
              + {{LIMB_WIDTH{1'b0}}, c_q};

        t_ext = {1'b0, s_ext[LIMB_WIDTH-1:0]}
              - {1'b0, p_limb}
              - {{LIMB_WIDTH{1'b0}}, w_q};
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    //
    // IDLE:
    //   Waits for start. Operands are latched so the requester may change
    //   a/b immediately after the capture edge. done is cleared on that same
    //   edge, so a requester that then waits on done only ever sees the new
    //   result.
    //
    // RUN:
    //   Retires one limb of S and of T per cycle.
    //
    // SEL:
    //   Makes the reduction decision. a + b >= p holds exactly when:
    //   - the sum carried out of the top bit (c = 1, so a + b >= 2^448 > p), or
    //   - the trial subtraction did not borrow (w = 0).
    //
    // start is only looked at in IDLE, so pulses during RUN/SEL are dropped.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        t_d     = t_q;
        c_d     = c_q;
        w_d     = w_q;
        sum_d   = sum_q;
        done_d  = done_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    c_d     = 1'b0;
                    w_d     = 1'b0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    state_d = RUN;
                end
            end

            RUN: begin
                s_d[cnt_q * LIMB_WIDTH +: LIMB_WIDTH] = s_ext[LIMB_WIDTH-1:0];
                t_d[cnt_q * LIMB_WIDTH +: LIMB_WIDTH] = t_ext[LIMB_WIDTH-1:0];
                c_d = s_ext[LIMB_WIDTH];
                w_d = t_ext[LIMB_WIDTH];

                if (cnt_q == LAST_LIMB) begin
                    state_d = SEL;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end

            SEL: begin
                if (c_q || !w_q) begin
                    sum_d = t_q;
                end else begin
                    sum_d = s_q;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    //
    // Reset aborts any operation in flight. The operand and partial-result
    // registers are cleared along with the control state, so no stale
    // values linger.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            t_q     <= '0;
            c_q     <= 1'b0;
            w_q     <= 1'b0;
            sum_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            t_q     <= t_d;
            c_q     <= c_d;
            w_q     <= w_d;
            sum_q   <= sum_d;
            done_q  <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs come straight from flops
    // -----------------------------------------------------------------------
    assign bus.sum  = sum_q;
    assign bus.done = done_q;

endmodule : add_mod

// File: tb/tb_add_mod.sv
// ---------------------------------------------------------------------------
// tb_add_mod
//
// Self-checking bench for add_mod.
//
// Expected results come from a plain-arithmetic model: the 449-bit sum of
// the operands, minus p once if it is >= p, truncated to 448 bits.
// p is built independently here.
// ---------------------------------------------------------------------------

module tb_add_mod;

    localparam int W = 448;

    logic clk;
    logic rst;

    int checks;
    int errors;

    logic [W:0]   p_wide;
    logic [W-1:0] p_val;

    add_mod_if bus ();

    add_mod u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string tag,
                               input logic [W-1:0] got,
                               input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns a uniformly random 448-bit value.
    function automatic logic [W-1:0] rand448();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < W / 32; i++) begin
            v = {v[W-33:0], 32'($urandom())};
        end
        return v;
    endfunction

    // Reference model: one conditional subtraction of p on the exact sum.
    function automatic logic [W-1:0] modelAdd(input logic [W-1:0] x,
                                              input logic [W-1:0] y);
        logic [W:0] full;
        full = {1'b0, x} + {1'b0, y};
        if (full >= p_wide) begin
            full = full - p_wide;
        end
        return full[W-1:0];
    endfunction

    // Issues one operation and checks it.
    // pulse_at > 0 injects a start pulse with different operands at that
    // many cycles into the run; the adder must ignore it.
    task automatic applyStimulus(input logic [W-1:0] op_a,
                                 input logic [W-1:0] op_b,
                                 input string        tag,
                                 input int           pulse_at);
        logic [W-1:0] exp;
        int k;

        exp = modelAdd(op_a, op_b);

        @(negedge clk);
        bus.a     = op_a;
        bus.b     = op_b;
        bus.start = 1'b1;

        // Operands may change freely after the capture edge.
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = rand448();
        bus.b     = rand448();
        checkOutput({tag, "/done_clr"}, {{(W-1){1'b0}}, bus.done}, '0);

        k = 0;
        while (!bus.done && k < 20) begin
            @(negedge clk);
            k++;
            if (k == pulse_at) begin
                bus.start = 1'b1;
                bus.a     = rand448();
                bus.b     = rand448();
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;

        checkOutput({tag, "/latency"}, W'(k), W'(8));
        checkOutput({tag, "/sum"}, bus.sum, exp);
    endtask

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;
        int k;

        checks = 0;
        errors = 0;

        p_wide = (449'd1 << 448) - (449'd1 << 224) - 449'd1;
        p_val  = p_wide[W-1:0];

        // ---------------------------------------------------------------
        // Reset state
        // ---------------------------------------------------------------
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset/sum", bus.sum, '0);
        checkOutput("reset/done", {{(W-1){1'b0}}, bus.done}, '0);
        rst = 1'b0;

        // ---------------------------------------------------------------
        // Directed corner cases
        // ---------------------------------------------------------------
        // No reduction: (2^444 - 1) + 1.
        applyStimulus((W'(1) << 444) - W'(1), W'(1), "no_reduce", 0);
        checkOutput("no_reduce/value", bus.sum, W'(1) << 444);

        // Wrap near the modulus.
        applyStimulus(p_val, W'(2), "wrap", 0);

        // Exact modulus: (p - 1) + 1 reduces to 0.
        applyStimulus(p_val - W'(1), W'(1), "exact_p", 0);
        checkOutput("exact_p/done", {{(W-1){1'b0}}, bus.done}, W'(1));

        // Carry out of bit 447: (p - 1) + (p - 1) = p - 2.
        applyStimulus(p_val - W'(1), p_val - W'(1), "carry", 0);
        checkOutput("carry/value", bus.sum, p_val - W'(2));

        // ---------------------------------------------------------------
        // Handshake: back-to-back start after done, and a start pulse
        // during RUN that must be ignored.
        // ---------------------------------------------------------------
        checkOutput("hs/done_before", {{(W-1){1'b0}}, bus.done}, W'(1));
        applyStimulus(rand448(), rand448(), "hs_b2b", 0);
        applyStimulus(rand448(), rand448(), "hs_busy_pulse", 3);

        // Done is a level and holds while idle.
        repeat (3) @(negedge clk);
        checkOutput("hs/done_hold", {{(W-1){1'b0}}, bus.done}, W'(1));

        // ---------------------------------------------------------------
        // Reset during RUN
        // ---------------------------------------------------------------
        @(negedge clk);
        bus.a     = rand448();
        bus.b     = rand448();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid/sum", bus.sum, '0);
        checkOutput("rst_mid/done", {{(W-1){1'b0}}, bus.done}, '0);
        @(negedge clk);
        rst = 1'b0;

        // No done may appear from the aborted run.
        k = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) k++;
        end
        checkOutput("rst_mid/no_done", W'(k), '0);
        applyStimulus(rand448(), rand448(), "rst_mid/after", 0);

        // ---------------------------------------------------------------
        // Random operands: mostly reduced inputs, some full-range inputs.
        // ---------------------------------------------------------------
        for (int n = 0; n < 24; n++) begin
            x = rand448();
            y = rand448();
            if (n % 3 != 0) begin
                if (x >= p_val) x = x - p_val;
                if (y >= p_val) y = y - p_val;
            end
            applyStimulus(x, y, $sformatf("rand%0d", n), (n % 4 == 1) ? 2 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop if the stimulus thread ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule : tb_add_mod
